lmem_wr_arbiter: RTL and testbench

LMEM_WR_ARBITER -- requirements
Module: lmem_wr_arbiter

---
 rtl/lmem_wr_arbiter_pkg.sv | 21 ++
 rtl/lmem_wr_arbiter_rr_pick.sv | 38 +++
 rtl/lmem_wr_arbiter.sv | 134 +++++++++++++
 tb/tb_lmem_wr_arbiter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/lmem_wr_arbiter_pkg.sv
// Shared types and helpers for the LMEM write-port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lmem_wr_arbiter_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } arb_state_e;

   // Ceiling log2 with clog2(1) == 0; usable in constant expressions.
   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/lmem_wr_arbiter_rr_pick.sv
// Round-robin priority pick: first set valid bit at or above ptr, wrapping.
// Latency: combinational.
// Backpressure: none; pure selection logic.
module rr_pick
   import lmem_wr_arbiter_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0]          valid,
   input  logic [clog2(N)-1:0]   ptr,
   output logic [N-1:0]          onehot,
   output logic [clog2(N)-1:0]   idx,
   output logic                  any
);

   localparam int IW = clog2(N);

   always_comb begin
      int j;
      logic [IW-1:0] jj;
      onehot = '0;
      idx    = '0;
      any    = 1'b0;
      j      = 0;
      jj     = '0;
      for (int k = 0; k < N; k++) begin
         j = int'(ptr) + k;
         if (j >= N) j = j - N;
         jj = IW'(j);
         if (!any && valid[jj]) begin
            any        = 1'b1;
            onehot[jj] = 1'b1;
            idx        = jj;
         end
      end
   end

endmodule

// File: rtl/lmem_wr_arbiter.sv
// Round-robin write arbiter for the single LMEM write port, with held bursts.
// Latency: accepted word appears on we_0/waddr_0/data_0 one cycle later.
// Backpressure: req_ready is combinational; at most one requester ready per cycle.
module lmem_wr_arbiter
   import lmem_wr_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH = 18,
   parameter int ADDR_WIDTH = 10,
   parameter int N_REQ      = 4,
   parameter int MAX_BURST  = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [N_REQ-1:0]            req_valid,
   input  logic [N_REQ-1:0]            req_last,
   input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
   input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
   output logic [N_REQ-1:0]            req_ready,
   output logic                        we_0,
   output logic [ADDR_WIDTH-1:0]       waddr_0,
   output logic [DATA_WIDTH-1:0]       data_0,
   output logic [clog2(N_REQ)-1:0]     grant_id,
   output logic                        busy,
   output logic [15:0]                 wr_count
);

   localparam int IW = clog2(N_REQ);
   localparam int BW = clog2(MAX_BURST) + 1;

   arb_state_e      state_q, state_nxt;
   logic [IW-1:0]   rr_ptr_q, rr_ptr_nxt;
   logic [IW-1:0]   grant_q, grant_nxt;
   logic [BW-1:0]   beat_q, beat_nxt, beat_inc;
   logic [IW-1:0]   sel_idx;
   logic            accept;

   logic [N_REQ-1:0] pick_onehot;
   logic [IW-1:0]    pick_idx;
   logic             pick_any;

   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_data;

   rr_pick #(
      .N (N_REQ)
   ) u_rr_pick (
      .valid  (req_valid),
      .ptr    (rr_ptr_q),
      .onehot (pick_onehot),
      .idx    (pick_idx),
      .any    (pick_any)
   );

   function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] i);
      if (int'(i) == N_REQ - 1) return '0;
      return i + IW'(1);
   endfunction

   assign sel_addr = req_addr[sel_idx*ADDR_WIDTH +: ADDR_WIDTH];
   assign sel_data = req_data[sel_idx*DATA_WIDTH +: DATA_WIDTH];

   always_comb begin
      state_nxt  = state_q;
      rr_ptr_nxt = rr_ptr_q;
      grant_nxt  = grant_q;
      beat_nxt   = beat_q;
      beat_inc   = beat_q + BW'(1);
      req_ready  = '0;
      sel_idx    = pick_idx;
      accept     = 1'b0;
      // Reset gates ready so nothing is accepted on a reset edge.
      if (!rst) begin
         unique case (state_q)
            IDLE: begin
               req_ready = pick_onehot;
               accept    = pick_any;
               sel_idx   = pick_idx;
               if (accept) begin
                  if (!req_last[pick_idx] && MAX_BURST > 1) begin
                     state_nxt = LOCKED;
                     grant_nxt = pick_idx;
                     beat_nxt  = BW'(1);
                  end else begin
                     rr_ptr_nxt = wrap_inc(pick_idx);
                  end
               end
            end
            LOCKED: begin
               req_ready[grant_q] = 1'b1;
               accept             = req_valid[grant_q];
               sel_idx            = grant_q;
               if (accept) begin
                  if (req_last[grant_q] || beat_inc == BW'(MAX_BURST)) begin
                     state_nxt  = IDLE;
                     rr_ptr_nxt = wrap_inc(grant_q);
                     beat_nxt   = '0;
                  end else begin
                     beat_nxt = beat_inc;
                  end
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         rr_ptr_q <= '0;
         grant_q  <= '0;
         beat_q   <= '0;
         we_0     <= 1'b0;
         waddr_0  <= '0;
         data_0   <= '0;
         wr_count <= '0;
      end else begin
         state_q  <= state_nxt;
         rr_ptr_q <= rr_ptr_nxt;
         grant_q  <= grant_nxt;
         beat_q   <= beat_nxt;
         we_0     <= accept;
         if (accept) begin
            waddr_0 <= sel_addr;
            data_0  <= sel_data;
         end
         if (accept && wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
      end
   end

   assign grant_id = grant_q;
   assign busy     = (state_q == LOCKED);

endmodule

// File: tb/tb_lmem_wr_arbiter.sv
// Directed vector bench for lmem_wr_arbiter (MAX_BURST 16 and 4 instances).
// Latency: checks ready pre-edge and the write port one cycle after acceptance.
// Backpressure: verifies exclusive ready, held bursts, stalls and forced release.
module tb_lmem_wr_arbiter;

   localparam int DW = 18;
   localparam int AW = 10;
   localparam int NR = 4;

   logic          clk;
   logic          rst;
   logic [NR-1:0] req_valid;
   logic [NR-1:0] req_last;
   logic [NR*AW-1:0] req_addr;
   logic [NR*DW-1:0] req_data;

   logic [NR-1:0] rdy_a, rdy_b;
   logic          we_a, we_b;
   logic [AW-1:0] waddr_a, waddr_b;
   logic [DW-1:0] data_a, data_b;
   logic [1:0]    gid_a, gid_b;
   logic          busy_a, busy_b;
   logic [15:0]   cnt_a, cnt_b;

   logic          chk4;
   logic [NR-1:0] o_ready;
   logic          o_we;
   logic [AW-1:0] o_waddr;
   logic [DW-1:0] o_data;
   logic [1:0]    o_gid;
   logic          o_busy;
   logic [15:0]   o_cnt;

   int n_checks;
   int n_errors;
   logic [AW-1:0] exp_waddr;
   logic [DW-1:0] exp_data;

   lmem_wr_arbiter #(
      .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .N_REQ (NR), .MAX_BURST (16)
   ) dut (
      .clk (clk), .rst (rst), .req_valid (req_valid), .req_last (req_last),
      .req_addr (req_addr), .req_data (req_data), .req_ready (rdy_a),
      .we_0 (we_a), .waddr_0 (waddr_a), .data_0 (data_a),
      .grant_id (gid_a), .busy (busy_a), .wr_count (cnt_a)
   );

   lmem_wr_arbiter #(
      .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .N_REQ (NR), .MAX_BURST (4)
   ) dut4 (
      .clk (clk), .rst (rst), .req_valid (req_valid), .req_last (req_last),
      .req_addr (req_addr), .req_data (req_data), .req_ready (rdy_b),
      .we_0 (we_b), .waddr_0 (waddr_b), .data_0 (data_b),
      .grant_id (gid_b), .busy (busy_b), .wr_count (cnt_b)
   );

   always_comb begin
      o_ready = chk4 ? rdy_b   : rdy_a;
      o_we    = chk4 ? we_b    : we_a;
      o_waddr = chk4 ? waddr_b : waddr_a;
      o_data  = chk4 ? data_b  : data_a;
      o_gid   = chk4 ? gid_b   : gid_a;
      o_busy  = chk4 ? busy_b  : busy_a;
      o_cnt   = chk4 ? cnt_b   : cnt_a;
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic [3:0] valid;
      logic [3:0] last;
      logic [9:0] addr;
      logic [3:0] exp_ready;
      logic       exp_we;
      int         exp_id;
      logic       exp_busy;
      int         exp_gid;
      int         exp_cnt;
   } vec_t;

   function automatic vec_t mk(logic r, logic [3:0] v, logic [3:0] l, logic [9:0] a,
                               logic [3:0] er, logic ew, int eid, logic eb, int eg, int ec);
      vec_t t;
      t.rst = r; t.valid = v; t.last = l; t.addr = a;
      t.exp_ready = er; t.exp_we = ew; t.exp_id = eid;
      t.exp_busy = eb; t.exp_gid = eg; t.exp_cnt = ec;
      return t;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Every requester sees the same address; data carries the requester id.
   task automatic drive(input logic r, input logic [3:0] v, input logic [3:0] l, input logic [9:0] a);
      rst       = r;
      req_valid = v;
      req_last  = l;
      for (int i = 0; i < NR; i++) begin
         req_addr[i*AW +: AW] = a;
         req_data[i*DW +: DW] = {8'(i), a};
      end
   endtask

   task automatic apply(input vec_t v, input string tag);
      drive(v.rst, v.valid, v.last, v.addr);
      #1;
      check({tag, " ready"}, 32'(o_ready), 32'(v.exp_ready));
      @(posedge clk);
      #1;
      if (v.rst) begin
         exp_waddr = '0;
         exp_data  = '0;
      end else if (v.exp_we) begin
         exp_waddr = v.addr;
         exp_data  = {8'(v.exp_id), v.addr};
      end
      check({tag, " we_0"},     32'(o_we),    32'(v.exp_we));
      check({tag, " waddr_0"},  32'(o_waddr), 32'(exp_waddr));
      check({tag, " data_0"},   32'(o_data),  32'(exp_data));
      check({tag, " busy"},     32'(o_busy),  32'(v.exp_busy));
      check({tag, " wr_count"}, 32'(o_cnt),   32'(v.exp_cnt));
      if (v.exp_busy) check({tag, " grant_id"}, 32'(o_gid), 32'(v.exp_gid));
   endtask

   vec_t tab16[$];
   vec_t tab4[$];

   initial begin
      n_checks  = 0;
      n_errors  = 0;
      chk4      = 1'b0;
      exp_waddr = '0;
      exp_data  = '0;
      drive(1'b1, 4'h0, 4'h0, 10'h0);

      //              rst valid last  addr    rdy  we id busy gid cnt
      tab16.push_back(mk(1, 4'hF, 4'hF, 10'h3FF, 4'h0, 0, 0, 0, 0, 0));
      tab16.push_back(mk(1, 4'hF, 4'hF, 10'h3FF, 4'h0, 0, 0, 0, 0, 0));
      tab16.push_back(mk(0, 4'hF, 4'hF, 10'h020, 4'h1, 1, 0, 0, 0, 1));
      tab16.push_back(mk(0, 4'hF, 4'hF, 10'h021, 4'h2, 1, 1, 0, 0, 2));
      tab16.push_back(mk(0, 4'hF, 4'hF, 10'h022, 4'h4, 1, 2, 0, 0, 3));
      tab16.push_back(mk(0, 4'hF, 4'hF, 10'h023, 4'h8, 1, 3, 0, 0, 4));
      tab16.push_back(mk(0, 4'h2, 4'h2, 10'h024, 4'h2, 1, 1, 0, 0, 5));
      // requester 2 holds the port for 5 words while requester 0 waits
      tab16.push_back(mk(0, 4'h5, 4'h0, 10'h010, 4'h4, 1, 2, 1, 2, 6));
      tab16.push_back(mk(0, 4'h5, 4'h0, 10'h011, 4'h4, 1, 2, 1, 2, 7));
      tab16.push_back(mk(0, 4'h5, 4'h0, 10'h012, 4'h4, 1, 2, 1, 2, 8));
      tab16.push_back(mk(0, 4'h5, 4'h0, 10'h013, 4'h4, 1, 2, 1, 2, 9));
      tab16.push_back(mk(0, 4'h5, 4'h4, 10'h014, 4'h4, 1, 2, 0, 0, 10));
      tab16.push_back(mk(0, 4'h5, 4'h5, 10'h030, 4'h1, 1, 0, 0, 0, 11));
      // requester 0 stalls 3 cycles mid-burst; others must stay blocked
      tab16.push_back(mk(0, 4'h1, 4'h0, 10'h040, 4'h1, 1, 0, 1, 0, 12));
      tab16.push_back(mk(0, 4'h1, 4'h0, 10'h041, 4'h1, 1, 0, 1, 0, 13));
      tab16.push_back(mk(0, 4'hE, 4'hE, 10'h0AA, 4'h1, 0, 0, 1, 0, 13));
      tab16.push_back(mk(0, 4'hE, 4'hE, 10'h0AB, 4'h1, 0, 0, 1, 0, 13));
      tab16.push_back(mk(0, 4'hE, 4'hE, 10'h0AC, 4'h1, 0, 0, 1, 0, 13));
      tab16.push_back(mk(0, 4'hF, 4'h1, 10'h042, 4'h1, 1, 0, 0, 0, 14));
      // reset during word 2 of a burst, then pointer must restart at 0
      tab16.push_back(mk(0, 4'h2, 4'h0, 10'h050, 4'h2, 1, 1, 1, 1, 15));
      tab16.push_back(mk(1, 4'h2, 4'h0, 10'h051, 4'h0, 0, 0, 0, 0, 0));
      tab16.push_back(mk(0, 4'h0, 4'h0, 10'h052, 4'h0, 0, 0, 0, 0, 0));
      tab16.push_back(mk(0, 4'hF, 4'hF, 10'h060, 4'h1, 1, 0, 0, 0, 1));

      // MAX_BURST=4: requester 1 never sets last, requester 3 waits
      tab4.push_back(mk(1, 4'h0, 4'h0, 10'h000, 4'h0, 0, 0, 0, 0, 0));
      tab4.push_back(mk(0, 4'hA, 4'h8, 10'h060, 4'h2, 1, 1, 1, 1, 1));
      tab4.push_back(mk(0, 4'hA, 4'h8, 10'h061, 4'h2, 1, 1, 1, 1, 2));
      tab4.push_back(mk(0, 4'hA, 4'h8, 10'h062, 4'h2, 1, 1, 1, 1, 3));
      tab4.push_back(mk(0, 4'hA, 4'h8, 10'h063, 4'h2, 1, 1, 0, 0, 4));
      tab4.push_back(mk(0, 4'hA, 4'h8, 10'h064, 4'h8, 1, 3, 0, 0, 5));
      tab4.push_back(mk(0, 4'h2, 4'h0, 10'h065, 4'h2, 1, 1, 1, 1, 6));
      tab4.push_back(mk(0, 4'h2, 4'h2, 10'h066, 4'h2, 1, 1, 0, 0, 7));

      for (int i = 0; i < tab16.size(); i++) apply(tab16[i], $sformatf("b16[%0d]", i));

      // wr_count saturation
      drive(1'b1, 4'h0, 4'h0, 10'h0);
      @(posedge clk);
      #1;
      check("sat reset wr_count", 32'(cnt_a), 32'h0);
      drive(1'b0, 4'h1, 4'h1, 10'h077);
      repeat (65534) @(posedge clk);
      #1;
      check("sat preload wr_count", 32'(cnt_a), 32'hFFFE);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         check($sformatf("sat[%0d] wr_count", k), 32'(cnt_a), 32'hFFFF);
         check($sformatf("sat[%0d] we_0", k), 32'(we_a), 32'h1);
      end

      chk4 = 1'b1;
      for (int i = 0; i < tab4.size(); i++) apply(tab4[i], $sformatf("b4[%0d]", i));

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
